// File: rtl/databuffer_pingpong_ctrl.sv
// databuffer_pingpong_ctrl
//   Ping-pong controller for two block buffers (bank0 / bank1) in the JPEG
//   encoder front end. A raster pixel stream is collected into a staging
//   vector. A full block is loaded into the free bank. Filled banks are
//   presented in order to the DCT stage.
//   Optional feature macro: DATABUF_BLKCNT_EN. It adds blk_count, which counts
//   load pulses, and ovf_err, a sticky flag for pixels offered during a long
//   load stall.
//
// Handshakes:
//   pix_valid/pix_ready: a pixel transfers on every clock edge where both are
//   high. pix_valid may be held while pix_ready is low. pix_ready depends only
//   on state (and sync_clr), never on pix_valid.
//   blk_valid/blk_done: blk_done is a 1-cycle pulse. It only takes effect
//   while blk_valid is high, and it releases the presented bank on that edge.
module databuffer_pingpong_ctrl #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 64,
  localparam int CNT_W      = $clog2(DEPTH) + 1,
  localparam int STAGE_W    = DATA_WIDTH * DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sync_clr,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic [STAGE_W-1:0]    stage_data,
  output logic [1:0]            buf_load,
  output logic [1:0]            buf_oe,
  output logic                  blk_valid,
  output logic                  blk_bank,
  input  logic                  blk_done,
`ifdef DATABUF_BLKCNT_EN
  output logic [15:0]           blk_count,
  output logic                  ovf_err,
`endif
  output logic [CNT_W-1:0]      fill_cnt,
  output logic                  dbg_wr_state   // 1 while waiting to load a bank
);

  typedef enum logic {
    WR_FILL      = 1'b0,
    WR_LOAD_WAIT = 1'b1
  } wr_state_e;

  wr_state_e          state_q, state_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic               stage_full_q, stage_full_d;
  logic [1:0]         bank_full_q, bank_full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
`ifdef DATABUF_BLKCNT_EN
  logic [15:0]        blk_count_q, blk_count_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               ovf_err_q, ovf_err_d;
`endif

  // Write FSM, bank flags and read pointer: next state and outputs.
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    stage_d      = stage_q;
    stage_full_d = stage_full_q;
    bank_full_d  = bank_full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    pix_ready    = 1'b0;
    buf_load     = 2'b00;
    blk_valid    = bank_full_q[rd_bank_q];
    buf_oe       = blk_valid ? (2'b01 << rd_bank_q) : 2'b00;

    // Release of the presented bank. It never targets the bank being loaded.
    if (blk_done && blk_valid) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end

    case (state_q)
      WR_FILL: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          // Pixel k goes to the k-th byte from the top (pixel 0 in the MSBs).
          for (int i = 0; i < DEPTH; i++) begin
            if (fill_cnt_q == CNT_W'(i)) begin
              stage_d[STAGE_W-1-DATA_WIDTH*i -: DATA_WIDTH] = pix_data;
            end
          end
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d      = WR_LOAD_WAIT;
            stage_full_d = 1'b1;
          end
        end
      end
      WR_LOAD_WAIT: begin
        // The staging vector stays stable. Load only when the target bank is free.
        if (!bank_full_q[wr_bank_q]) begin
          buf_load[wr_bank_q]    = 1'b1;
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d              = ~wr_bank_q;
          fill_cnt_d             = '0;
          stage_full_d           = 1'b0;
          state_d                = WR_FILL;
        end
      end
      default: state_d = WR_FILL;
    endcase

    // Frame-start clear overrides every event of this cycle.
    if (sync_clr) begin
      state_d      = WR_FILL;
      fill_cnt_d   = '0;
      stage_d      = '0;
      stage_full_d = 1'b0;
      bank_full_d  = 2'b00;
      wr_bank_d    = 1'b0;
      rd_bank_d    = 1'b0;
      pix_ready    = 1'b0;
      buf_load     = 2'b00;
    end
  end

`ifdef DATABUF_BLKCNT_EN
  // Load counter and load-stall overflow detection.
  always_comb begin
    blk_count_d = blk_count_q + ((|buf_load) ? 16'd1 : 16'd0);
    ovf_err_d   = ovf_err_q;
    wait_cnt_d  = '0;
    if (state_q == WR_LOAD_WAIT) begin
      if (pix_valid && (wait_cnt_q >= CNT_W'(DEPTH))) ovf_err_d = 1'b1;
      if (!(|buf_load) && (wait_cnt_q != CNT_W'(DEPTH))) wait_cnt_d = wait_cnt_q + 1'b1;
      else if (!(|buf_load)) wait_cnt_d = wait_cnt_q;
    end
    if (sync_clr) begin
      blk_count_d = '0;
      ovf_err_d   = 1'b0;
      wait_cnt_d  = '0;
    end
  end

  // Counter and overflow registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blk_count_q <= '0;
      wait_cnt_q  <= '0;
      ovf_err_q   <= 1'b0;
    end else begin
      blk_count_q <= blk_count_d;
      wait_cnt_q  <= wait_cnt_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign blk_count = blk_count_q;
  assign ovf_err   = ovf_err_q;
`endif

  // State, staging and bank-flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WR_FILL;
      fill_cnt_q   <= '0;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      bank_full_q  <= 2'b00;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      stage_q      <= stage_d;
      stage_full_q <= stage_full_d;
      bank_full_q  <= bank_full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
    end
  end

  assign stage_data   = stage_q;
  assign fill_cnt     = fill_cnt_q;
  assign blk_bank     = rd_bank_q;
  assign dbg_wr_state = state_q;

endmodule

// File: tb/tb_databuffer_pingpong_ctrl.sv
// Testbench for databuffer_pingpong_ctrl.
// Reference model: a pixel count, a staging vector, and a queue of the blocks
// currently held in the banks (oldest first). The bank roles are derived from
// the total number of loads and releases.
module tb_databuffer_pingpong_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int SW    = DW * DEPTH;

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          reset_n, sync_clr, pix_valid, blk_done;
  logic [DW-1:0] pix_data;
  logic          pix_ready, blk_valid, blk_bank, dbg_wr_state;
  logic [SW-1:0] stage_data;
  logic [1:0]    buf_load, buf_oe;
  logic [6:0]    fill_cnt;
`ifdef DATABUF_BLKCNT_EN
  logic [15:0]   blk_count;
  logic          ovf_err;
`endif

  always #5 clock = ~clock;

  databuffer_pingpong_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .sync_clr(sync_clr),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .stage_data(stage_data), .buf_load(buf_load), .buf_oe(buf_oe),
    .blk_valid(blk_valid), .blk_bank(blk_bank), .blk_done(blk_done),
`ifdef DATABUF_BLKCNT_EN
    .blk_count(blk_count), .ovf_err(ovf_err),
`endif
    .fill_cnt(fill_cnt), .dbg_wr_state(dbg_wr_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int            m_cnt, m_loads, m_rels, m_blkcnt, m_wait;
  logic          m_ovf;
  logic [SW-1:0] m_stage;
  logic [SW-1:0] exp_q[$];

  task automatic model_reset();
    m_cnt = 0; m_loads = 0; m_rels = 0; m_blkcnt = 0; m_wait = 0;
    m_ovf = 1'b0; m_stage = '0; exp_q.delete();
  endtask

  function automatic logic e_ready();
    return (m_cnt < DEPTH);
  endfunction
  function automatic logic [1:0] e_load();
    if (m_cnt == DEPTH && exp_q.size() < 2) return (m_loads % 2 == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction
  function automatic logic e_valid();
    return (exp_q.size() > 0);
  endfunction
  function automatic logic e_bank();
    return (m_rels % 2 == 1);
  endfunction
  function automatic logic [1:0] e_oe();
    if (!e_valid()) return 2'b00;
    return e_bank() ? 2'b10 : 2'b01;
  endfunction

  // Applies the inputs currently driven to the model, as the coming edge will.
  task automatic model_edge();
    int occ;
    occ = exp_q.size();
    if (sync_clr) begin
      model_reset();
      return;
    end
    if (m_cnt == DEPTH && pix_valid && m_wait >= DEPTH) m_ovf = 1'b1;
    if (blk_done && occ > 0) begin
      void'(exp_q.pop_front());
      m_rels++;
    end
    if (m_cnt == DEPTH && occ < 2) begin
      exp_q.push_back(m_stage);
      m_loads++;
      m_cnt = 0;
      m_wait = 0;
      m_blkcnt = (m_blkcnt + 1) % 65536;
    end else if (m_cnt == DEPTH) begin
      m_wait++;
    end else begin
      m_wait = 0;
      if (pix_valid) begin
        m_stage[SW-1-DW*m_cnt -: DW] = pix_data;
        m_cnt++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic done, input logic sc);
    pix_valid = v; pix_data = d; blk_done = done; sync_clr = sc;
    @(negedge clock);
  endtask

  task automatic advance();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    pix_valid = 0; pix_data = '0; blk_done = 0; sync_clr = 0;
    reset_n = 0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0;
    model_reset();
    drive(0, '0, 0, 0);
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready got=%b exp=1", pix_ready); end
    checks++; if (fill_cnt !== 7'd0) begin errors++; $display("FAIL reset_fill_cnt got=%0d exp=0", fill_cnt); end
    checks++; if (stage_data !== '0) begin errors++; $display("FAIL reset_stage_data got=%h exp=0", stage_data[63:0]); end
    checks++; if (buf_load !== 2'b00) begin errors++; $display("FAIL reset_buf_load got=%b exp=00", buf_load); end
    checks++; if (buf_oe !== 2'b00) begin errors++; $display("FAIL reset_buf_oe got=%b exp=00", buf_oe); end
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid got=%b exp=0", blk_valid); end
    checks++; if (blk_bank !== 1'b0) begin errors++; $display("FAIL reset_blk_bank got=%b exp=0", blk_bank); end
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  task automatic test_first_block();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, DW'(k), 0, 0);
      checks++;
      if (pix_ready !== 1'b1 || fill_cnt !== 7'(k)) begin
        errors++; $display("FAIL fill_step k=%0d ready=%b cnt=%0d exp ready=1 cnt=%0d", k, pix_ready, fill_cnt, k);
      end
      advance();
    end
    drive(0, '0, 0, 0);
    checks++; if (buf_load !== 2'b01) begin errors++; $display("FAIL first_load got=%b exp=01", buf_load); end
    checks++; if (stage_data[SW-1 -: 8] !== 8'h00) begin errors++; $display("FAIL first_msb got=%h exp=00", stage_data[SW-1 -: 8]); end
    checks++; if (stage_data[7:0] !== 8'h3F) begin errors++; $display("FAIL first_lsb got=%h exp=3f", stage_data[7:0]); end
    checks++; if (pix_ready !== 1'b0 || fill_cnt !== 7'd64) begin errors++; $display("FAIL first_wait ready=%b cnt=%0d exp ready=0 cnt=64", pix_ready, fill_cnt); end
    checks++; if (stage_data !== m_stage) begin errors++; $display("FAIL first_stage got=%h exp=%h", stage_data[127:0], m_stage[127:0]); end
    advance();
    drive(0, '0, 0, 0);
    checks++; if (blk_valid !== 1'b1 || blk_bank !== 1'b0 || buf_oe !== 2'b01) begin
      errors++; $display("FAIL first_present valid=%b bank=%b oe=%b exp 1/0/01", blk_valid, blk_bank, buf_oe);
    end
    checks++; if (pix_ready !== 1'b1 || fill_cnt !== 7'd0 || buf_load !== 2'b00) begin
      errors++; $display("FAIL first_after ready=%b cnt=%0d load=%b exp 1/0/00", pix_ready, fill_cnt, buf_load);
    end
    advance();
  endtask

  task automatic test_backpressure();
    int stall;
    stall = 0;
    do_reset();
    for (int cyc = 0; cyc < 400 && stall < 5; cyc++) begin
      drive(1, DW'($urandom_range(0, 255)), 0, 0);
      checks++; if (pix_ready !== e_ready()) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, pix_ready, e_ready()); end
      checks++; if (buf_load !== e_load()) begin errors++; $display("FAIL bp_load cyc=%0d got=%b exp=%b", cyc, buf_load, e_load()); end
      if (m_cnt == DEPTH && exp_q.size() == 2) stall++;
      advance();
    end
    checks++; if (stall != 5) begin errors++; $display("FAIL bp_timeout stall=%0d exp=5", stall); end
    drive(0, '0, 1, 0);
    checks++; if (pix_ready !== 1'b0 || buf_load !== 2'b00) begin errors++; $display("FAIL bp_stuck ready=%b load=%b exp 0/00", pix_ready, buf_load); end
    checks++; if (blk_valid !== 1'b1 || blk_bank !== 1'b0) begin errors++; $display("FAIL bp_present valid=%b bank=%b exp 1/0", blk_valid, blk_bank); end
    advance();
    drive(0, '0, 0, 0);
    checks++; if (buf_load !== 2'b01 || pix_ready !== 1'b0) begin errors++; $display("FAIL bp_reload load=%b ready=%b exp 01/0", buf_load, pix_ready); end
    checks++; if (blk_bank !== 1'b1 || blk_valid !== 1'b1) begin errors++; $display("FAIL bp_next_bank bank=%b valid=%b exp 1/1", blk_bank, blk_valid); end
    advance();
    drive(0, '0, 0, 0);
    checks++; if (pix_ready !== 1'b1 || fill_cnt !== 7'd0) begin errors++; $display("FAIL bp_resume ready=%b cnt=%0d exp 1/0", pix_ready, fill_cnt); end
    advance();
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin drive(1, DW'($urandom_range(0, 255)), 0, 0); advance(); end
    drive(0, '0, 0, 0);
    advance();
    for (int k = 0; k < DEPTH; k++) begin drive(1, DW'($urandom_range(0, 255)), 0, 0); advance(); end
    drive(0, '0, 1, 0);
    checks++; if (buf_load !== 2'b10 || blk_valid !== 1'b1 || blk_bank !== 1'b0) begin
      errors++; $display("FAIL sim_edge load=%b valid=%b bank=%b exp 10/1/0", buf_load, blk_valid, blk_bank);
    end
    advance();
    drive(0, '0, 0, 0);
    checks++; if (blk_valid !== 1'b1 || blk_bank !== 1'b1 || buf_oe !== 2'b10) begin
      errors++; $display("FAIL sim_after valid=%b bank=%b oe=%b exp 1/1/10", blk_valid, blk_bank, buf_oe);
    end
    advance();
    drive(0, '0, 1, 0);
    advance();
    drive(0, '0, 0, 0);
    checks++; if (blk_valid !== 1'b0 || blk_bank !== 1'b0 || buf_oe !== 2'b00) begin
      errors++; $display("FAIL sim_drain valid=%b bank=%b oe=%b exp 0/0/00", blk_valid, blk_bank, buf_oe);
    end
    advance();
  endtask

  task automatic test_spurious_done();
    do_reset();
    drive(0, '0, 1, 0);
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL spur_valid got=%b exp=0", blk_valid); end
    advance();
    drive(0, '0, 0, 0);
    checks++; if (blk_bank !== 1'b0 || blk_valid !== 1'b0 || pix_ready !== 1'b1) begin
      errors++; $display("FAIL spur_state bank=%b valid=%b ready=%b exp 0/0/1", blk_bank, blk_valid, pix_ready);
    end
    advance();
    for (int k = 0; k < DEPTH; k++) begin drive(1, DW'($urandom_range(0, 255)), 0, 0); advance(); end
    drive(0, '0, 0, 0);
    checks++; if (buf_load !== 2'b01) begin errors++; $display("FAIL spur_load got=%b exp=01", buf_load); end
    advance();
    drive(0, '0, 0, 0);
    checks++; if (blk_bank !== 1'b0 || blk_valid !== 1'b1) begin errors++; $display("FAIL spur_present bank=%b valid=%b exp 0/1", blk_bank, blk_valid); end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 30; k++) begin drive(1, DW'(8'hA0 + k), 0, 0); advance(); end
    pix_valid = 1;
    #2;
    reset_n = 0;
    model_reset();
    @(negedge clock);
    checks++; if (fill_cnt !== 7'd0 || pix_ready !== 1'b1) begin errors++; $display("FAIL rmid_cnt cnt=%0d ready=%b exp 0/1", fill_cnt, pix_ready); end
    checks++; if (stage_data !== '0 || blk_valid !== 1'b0) begin errors++; $display("FAIL rmid_clear stage=%h valid=%b exp 0/0", stage_data[63:0], blk_valid); end
    @(posedge clock);
    #1;
    reset_n = 1;
    for (int k = 0; k < DEPTH; k++) begin drive(1, DW'($urandom_range(0, 255)), 0, 0); advance(); end
    drive(0, '0, 0, 0);
    checks++; if (buf_load !== 2'b01) begin errors++; $display("FAIL rmid_load got=%b exp=01", buf_load); end
    checks++; if (stage_data !== m_stage) begin errors++; $display("FAIL rmid_stage got=%h exp=%h", stage_data[SW-1 -: 128], m_stage[SW-1 -: 128]); end
    advance();
  endtask

  task automatic test_sync_clr();
    do_reset();
    for (int k = 0; k < DEPTH + 21; k++) begin drive(1, DW'($urandom_range(0, 255)), 0, 0); advance(); end
    drive(1, 8'h55, 1, 1);
    advance();
    drive(0, '0, 0, 0);
    checks++; if (fill_cnt !== 7'd0 || stage_data !== '0 || pix_ready !== 1'b1) begin
      errors++; $display("FAIL sclr_write cnt=%0d stage=%h ready=%b exp 0/0/1", fill_cnt, stage_data[63:0], pix_ready);
    end
    checks++; if (blk_valid !== 1'b0 || blk_bank !== 1'b0 || buf_oe !== 2'b00 || buf_load !== 2'b00) begin
      errors++; $display("FAIL sclr_read valid=%b bank=%b oe=%b load=%b exp 0/0/00/00", blk_valid, blk_bank, buf_oe, buf_load);
    end
    advance();
  endtask

`ifdef DATABUF_BLKCNT_EN
  task automatic test_blkcnt();
    do_reset();
    for (int c = 0; c < 400 && m_loads < 3; c++) begin drive(1, DW'($urandom_range(0, 255)), 1, 0); advance(); end
    drive(0, '0, 0, 0);
    checks++; if (blk_count !== 16'd3 || ovf_err !== 1'b0) begin errors++; $display("FAIL bcnt_three got=%0d ovf=%b exp 3/0", blk_count, ovf_err); end
    advance();
    drive(0, '0, 0, 1);
    advance();
    drive(0, '0, 0, 0);
    checks++; if (blk_count !== 16'd0 || blk_valid !== 1'b0 || fill_cnt !== 7'd0) begin
      errors++; $display("FAIL bcnt_clear cnt=%0d valid=%b fill=%0d exp 0/0/0", blk_count, blk_valid, fill_cnt);
    end
    advance();
    for (int c = 0; c < 300 && !(m_cnt == DEPTH && exp_q.size() == 2); c++) begin drive(1, DW'($urandom_range(0, 255)), 0, 0); advance(); end
    checks++; if (!(m_cnt == DEPTH && exp_q.size() == 2)) begin errors++; $display("FAIL ovf_setup_timeout cnt=%0d occ=%0d exp 64/2", m_cnt, exp_q.size()); end
    for (int n = 0; n < DEPTH; n++) begin drive(1, '0, 0, 0); advance(); end
    drive(0, '0, 0, 0);
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", ovf_err); end
    advance();
    drive(1, '0, 0, 0);
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_idle got=%b exp=0", ovf_err); end
    advance();
    drive(0, '0, 0, 0);
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
    advance();
  endtask
`endif

  task automatic test_random();
    logic v, dn, sc;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v  = ($urandom_range(0, 3) != 0);
      dn = ($urandom_range(0, 7) == 0);
      sc = ($urandom_range(0, 499) == 0);
      drive(v, DW'($urandom_range(0, 255)), dn, sc);
      if (!sc) begin
        checks++; if (pix_ready !== e_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, pix_ready, e_ready()); end
        checks++; if (buf_load !== e_load()) begin errors++; $display("FAIL rnd_load cyc=%0d got=%b exp=%b", cyc, buf_load, e_load()); end
      end
      checks++; if (fill_cnt !== 7'(m_cnt)) begin errors++; $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", cyc, fill_cnt, m_cnt); end
      checks++; if (stage_data !== m_stage) begin errors++; $display("FAIL rnd_stage cyc=%0d got=%h exp=%h", cyc, stage_data[127:0], m_stage[127:0]); end
      checks++; if (blk_valid !== e_valid()) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, blk_valid, e_valid()); end
      checks++; if (blk_bank !== e_bank()) begin errors++; $display("FAIL rnd_bank cyc=%0d got=%b exp=%b", cyc, blk_bank, e_bank()); end
      checks++; if (buf_oe !== e_oe()) begin errors++; $display("FAIL rnd_oe cyc=%0d got=%b exp=%b", cyc, buf_oe, e_oe()); end
`ifdef DATABUF_BLKCNT_EN
      checks++; if (blk_count !== 16'(m_blkcnt)) begin errors++; $display("FAIL rnd_blkcnt cyc=%0d got=%0d exp=%0d", cyc, blk_count, m_blkcnt); end
      checks++; if (ovf_err !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, ovf_err, m_ovf); end
`endif
      advance();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 0; sync_clr = 0; pix_valid = 0; pix_data = '0; blk_done = 0;
    model_reset();
    test_reset();
    test_first_block();
    test_backpressure();
    test_simultaneous();
    test_spurious_done();
    test_reset_mid();
    test_sync_clr();
`ifdef DATABUF_BLKCNT_EN
    test_blkcnt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
